// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: format decode, operand read with write-back bypass,
// immediate generation and the ID/EX pipeline register with stall, flush and write-back snooping.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instruction,
  input  logic [XLEN-1:0] if_pc,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_wEn,
  input  logic [4:0]      wb_write_sel,
  input  logic [XLEN-1:0] wb_write_data,
  output logic [4:0]      read_sel1,
  output logic [4:0]      read_sel2,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_rs1_data,
  output logic [XLEN-1:0] id_rs2_data,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rd,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic            id_reg_write,
  output logic            id_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  opcode;
  logic        uses_rs1, uses_rs2, writes_rd;
  logic [31:0] imm;
  logic [4:0]  rd_field;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode   = if_instruction[6:0];
  assign rd_field = if_instruction[11:7];

  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      OPC_OP:                          fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:  fmt = FMT_I;
      OPC_STORE:                       fmt = FMT_S;
      OPC_BRANCH:                      fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:              fmt = FMT_U;
      OPC_JAL:                         fmt = FMT_J;
      default:                         fmt = FMT_BAD;
    endcase
  end

  assign uses_rs1  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign uses_rs2  = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  assign writes_rd = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);

  assign read_sel1 = (if_valid && uses_rs1) ? if_instruction[19:15] : 5'd0;
  assign read_sel2 = (if_valid && uses_rs2) ? if_instruction[24:20] : 5'd0;

  // The select==0 test comes first so a write-back aimed at x0 can never bypass.
  always_comb begin
    rs1_val = read_data1;
    if (read_sel1 == 5'd0)
      rs1_val = '0;
    else if (wb_wEn && (wb_write_sel == read_sel1))
      rs1_val = wb_write_data;
  end

  always_comb begin
    rs2_val = read_data2;
    if (read_sel2 == 5'd0)
      rs2_val = '0;
    else if (wb_wEn && (wb_write_sel == read_sel2))
      rs2_val = wb_write_data;
  end

  always_comb begin
    imm = 32'd0;
    case (fmt)
      FMT_I: imm = {{20{if_instruction[31]}}, if_instruction[31:20]};
      FMT_S: imm = {{20{if_instruction[31]}}, if_instruction[31:25], if_instruction[11:7]};
      FMT_B: imm = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                    if_instruction[30:25], if_instruction[11:8], 1'b0};
      FMT_U: imm = {if_instruction[31:12], 12'd0};
      FMT_J: imm = {{11{if_instruction[31]}}, if_instruction[31], if_instruction[19:12],
                    if_instruction[20], if_instruction[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rd_q, rd_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [6:0]      funct7_q, funct7_d;
  logic            reg_write_q, reg_write_d;
  logic            illegal_q, illegal_d;
  logic [4:0]      rs1_idx_q, rs1_idx_d;
  logic [4:0]      rs2_idx_q, rs2_idx_d;

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    opcode_d    = opcode_q;
    funct3_d    = funct3_q;
    funct7_d    = funct7_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    if (flush) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rd_d        = 5'd0;
      opcode_d    = 7'd0;
      funct3_d    = 3'd0;
      funct7_d    = 7'd0;
      reg_write_d = 1'b0;
      illegal_d   = 1'b0;
      rs1_idx_d   = 5'd0;
      rs2_idx_d   = 5'd0;
    end else if (stall) begin
      // Held indices are 0 for unused sources, so the x0 guard also covers them.
      if (wb_wEn && (wb_write_sel != 5'd0) && (wb_write_sel == rs1_idx_q))
        rs1_data_d = wb_write_data;
      if (wb_wEn && (wb_write_sel != 5'd0) && (wb_write_sel == rs2_idx_q))
        rs2_data_d = wb_write_data;
    end else if (if_valid) begin
      valid_d     = 1'b1;
      pc_d        = if_pc;
      rs1_data_d  = rs1_val;
      rs2_data_d  = rs2_val;
      imm_d       = imm;
      rd_d        = writes_rd ? rd_field : 5'd0;
      opcode_d    = opcode;
      funct3_d    = if_instruction[14:12];
      funct7_d    = if_instruction[31:25];
      reg_write_d = writes_rd && (rd_field != 5'd0);
      illegal_d   = (fmt == FMT_BAD);
      rs1_idx_d   = read_sel1;
      rs2_idx_d   = read_sel2;
    end else begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rd_d        = 5'd0;
      opcode_d    = 7'd0;
      funct3_d    = 3'd0;
      funct7_d    = 7'd0;
      reg_write_d = 1'b0;
      illegal_d   = 1'b0;
      rs1_idx_d   = 5'd0;
      rs2_idx_d   = 5'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rd_q        <= 5'd0;
      opcode_q    <= 7'd0;
      funct3_q    <= 3'd0;
      funct7_q    <= 7'd0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      rs1_idx_q   <= 5'd0;
      rs2_idx_q   <= 5'd0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      opcode_q    <= opcode_d;
      funct3_q    <= funct3_d;
      funct7_q    <= funct7_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
    end
  end

  assign id_valid     = valid_q;
  assign id_pc        = pc_q;
  assign id_rs1_data  = rs1_data_q;
  assign id_rs2_data  = rs2_data_q;
  assign id_imm       = imm_q;
  assign id_rd        = rd_q;
  assign id_opcode    = opcode_q;
  assign id_funct3    = funct3_q;
  assign id_funct7    = funct7_q;
  assign id_reg_write = reg_write_q;
  assign id_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with a small register-file model.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset, if_valid, stall, flush, wb_wEn;
  logic [31:0] if_instruction, if_pc, wb_write_data;
  logic [4:0]  wb_write_sel;
  logic [4:0]  read_sel1, read_sel2;
  logic [31:0] read_data1, read_data2;
  logic        id_valid, id_reg_write, id_illegal;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rd;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;

  always #5 clock = ~clock;

  decode_stage #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_instruction(if_instruction),
    .if_pc(if_pc), .stall(stall), .flush(flush), .wb_wEn(wb_wEn),
    .wb_write_sel(wb_write_sel), .wb_write_data(wb_write_data),
    .read_sel1(read_sel1), .read_sel2(read_sel2),
    .read_data1(read_data1), .read_data2(read_data2),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_funct7(id_funct7), .id_reg_write(id_reg_write), .id_illegal(id_illegal)
  );

  // Register file model: combinational read, write at the clock edge, x0 hard-wired.
  logic [31:0] regs [32];
  initial for (int i = 0; i < 32; i++) regs[i] = 32'd0;
  always @(posedge clock) if (wb_wEn && wb_write_sel != 5'd0) regs[wb_write_sel] <= wb_write_data;
  assign read_data1 = regs[read_sel1];
  assign read_data2 = regs[read_sel2];

  typedef struct {
    int unsigned cyc;
    logic        valid;
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        rw, ill;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [31:0] pc, rs1, rs2, imm,
                              input logic [4:0] rd, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic rw, ill);
    exp_t e;
    e.cyc = 0; e.valid = v; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.rd = rd; e.op = op; e.f3 = f3; e.f7 = f7; e.rw = rw; e.ill = ill;
    return e;
  endfunction

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("id_valid",     {31'd0, id_valid},     {31'd0, e.valid});
      chk("id_pc",        id_pc,                 e.pc);
      chk("id_rs1_data",  id_rs1_data,           e.rs1);
      chk("id_rs2_data",  id_rs2_data,           e.rs2);
      chk("id_imm",       id_imm,                e.imm);
      chk("id_rd",        {27'd0, id_rd},        {27'd0, e.rd});
      chk("id_opcode",    {25'd0, id_opcode},    {25'd0, e.op});
      chk("id_funct3",    {29'd0, id_funct3},    {29'd0, e.f3});
      chk("id_funct7",    {25'd0, id_funct7},    {25'd0, e.f7});
      chk("id_reg_write", {31'd0, id_reg_write}, {31'd0, e.rw});
      chk("id_illegal",   {31'd0, id_illegal},   {31'd0, e.ill});
    end
  end

  task automatic step(input logic rst, stl, fl, v, input logic [31:0] ins, pc,
                      input logic wen, input logic [4:0] wsel, input logic [31:0] wdata,
                      input exp_t e);
    exp_t x;
    @(posedge clock);
    #1;
    reset = rst; stall = stl; flush = fl; if_valid = v; if_instruction = ins; if_pc = pc;
    wb_wEn = wen; wb_write_sel = wsel; wb_write_data = wdata;
    x = e;
    x.cyc = cyc + 1;
    sb.push_back(x);
  endtask

  exp_t zero, e_add5, e_add9, e_x0;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; if_valid = 1'b0; if_instruction = 32'd0;
    if_pc = 32'd0; wb_wEn = 1'b0; wb_write_sel = 5'd0; wb_write_data = 32'd0;
    zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step(1, 0, 0, 1, 32'hFFF00293, 32'h100, 0, 0, 0, zero);
    step(1, 0, 0, 1, 32'hFFF00293, 32'h100, 0, 0, 0, zero);
    // addi x5,x0,-1
    step(0, 0, 0, 1, 32'hFFF00293, 32'h100, 0, 0, 0,
         mk(1, 32'h100, 0, 0, 32'hFFFFFFFF, 5, 7'h13, 0, 7'h7F, 1, 0));
    // add x3,x2,x2 with same-cycle write-back of x2
    step(0, 0, 0, 1, 32'h002101B3, 32'h104, 1, 2, 32'hDEADBEEF,
         mk(1, 32'h104, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 7'h33, 0, 0, 1, 0));
    #1;
    chk("read_sel1_add", {27'd0, read_sel1}, 32'd2);
    chk("read_sel2_add", {27'd0, read_sel2}, 32'd2);
    // lui x1,0x12345
    step(0, 0, 0, 1, 32'h123450B7, 32'h108, 0, 0, 0,
         mk(1, 32'h108, 0, 0, 32'h12345000, 1, 7'h37, 3'd5, 7'h09, 1, 0));
    #1;
    chk("read_sel1_lui", {27'd0, read_sel1}, 32'd0);
    // beq x0,x0,-4
    step(0, 0, 0, 1, 32'hFE000EE3, 32'h10C, 0, 0, 0,
         mk(1, 32'h10C, 0, 0, 32'hFFFFFFFC, 0, 7'h63, 0, 7'h7F, 0, 0));
    // bubble while x2 <- 5
    step(0, 0, 0, 0, 32'd0, 32'd0, 1, 2, 32'd5, zero);
    e_add5 = mk(1, 32'h110, 32'd5, 32'd5, 0, 3, 7'h33, 0, 0, 1, 0);
    e_add9 = mk(1, 32'h110, 32'd9, 32'd9, 0, 3, 7'h33, 0, 0, 1, 0);
    step(0, 0, 0, 1, 32'h002101B3, 32'h110, 0, 0, 0, e_add5);
    // three stall cycles, x2 <- 9 in the second; a new instruction waits at the input
    step(0, 1, 0, 1, 32'h123450B7, 32'h114, 0, 0, 0, e_add5);
    step(0, 1, 0, 1, 32'h123450B7, 32'h114, 1, 2, 32'd9, e_add9);
    step(0, 1, 0, 1, 32'h123450B7, 32'h114, 0, 0, 0, e_add9);
    // flush beats stall
    step(0, 1, 1, 1, 32'h002101B3, 32'h114, 0, 0, 0, zero);
    // ecall is illegal
    step(0, 0, 0, 1, 32'h00000073, 32'h118, 0, 0, 0,
         mk(1, 32'h118, 0, 0, 0, 0, 7'h73, 0, 0, 0, 1));
    // add x3,x0,x0 with write-back to x0
    e_x0 = mk(1, 32'h11C, 0, 0, 0, 3, 7'h33, 0, 0, 1, 0);
    step(0, 0, 0, 1, 32'h000001B3, 32'h11C, 1, 0, 32'h1234, e_x0);
    // x0 write-back during stall must not snoop
    step(0, 1, 0, 1, 32'h000001B3, 32'h120, 1, 0, 32'h1234, e_x0);
    // reset beats stall mid-stream
    step(1, 1, 0, 1, 32'h002101B3, 32'h124, 0, 0, 0, zero);
    step(0, 0, 0, 0, 32'd0, 32'd0, 0, 0, 0, zero);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode pipeline stage of the RV32I core, placed directly upstream of `regFile`. It decodes the fetched instruction and drives `regFile`'s two read selects. It captures the operands with write-back bypass, generates the sign-extended immediate, and registers everything into the ID/EX pipeline register. The register supports stall, flush and write-back snooping.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clock`  in  1  — the single clock; all state updates on its rising edge.
- `reset`  in  1  — synchronous, active-high.
- `if_valid`  in  1  — `if_instruction` / `if_pc` carry a real instruction.
- `if_instruction`  in  32  — fetched instruction word.
- `if_pc`  in  32  — PC of `if_instruction`.
- `stall`  in  1  — hold the ID/EX register.
- `flush`  in  1  — kill the ID/EX contents.
- `wb_wEn`  in  1  — write-back write enable (same signal as `regFile.wEn`).
- `wb_write_sel`  in  5  — write-back destination register.
- `wb_write_data`  in  32  — write-back data.
- `read_sel1`, `read_sel2`  out  5  — to `regFile`. Combinational.
- `read_data1`, `read_data2`  in  32  — from `regFile`. Combinational read; the write takes effect at the clock edge.
- `id_valid`  out  1 — registered.
- `id_pc`  out  32 — registered.
- `id_rs1_data`, `id_rs2_data`  out  32 — registered.
- `id_imm`  out  32 — registered.
- `id_rd`  out  5 — registered.
- `id_opcode`  out  7 — registered.
- `id_funct3`  out  3 — registered.
- `id_funct7`  out  7 — registered.
- `id_reg_write`  out  1 — registered.
- `id_illegal`  out  1 — registered.

## Operation
Instruction format is selected by opcode [6:0]:
- R-type: OP `0110011`.
- I-type: OP-IMM `0010011`, LOAD `0000011`, JALR `1100111`.
- S-type: STORE `0100011`.
- B-type: BRANCH `1100011`.
- U-type: LUI `0110111`, AUIPC `0010111`.
- J-type: JAL `1101111`.
- Any other opcode, including SYSTEM and FENCE, is illegal.

Read selects:
- `read_sel1` = instr[19:15] for R/I/S/B formats; otherwise 0.
- `read_sel2` = instr[24:20] for R/S/B formats; otherwise 0.
- Both selects are 0 when `if_valid`=0.

Operand selection, per source, in priority order:
1. Select = 0 → 0.
2. `wb_wEn`=1 and `wb_write_sel` = select → `wb_write_data` (bypass).
3. Otherwise → `read_data`.

Immediate (all sign-extended from instr[31]):
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}, no extension.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R or illegal: 0.

Destination and flags:
- `id_reg_write` = 1 only for R, I, U and J formats with rd ≠ 0, and only when the instruction is legal.
- `id_rd` = instr[11:7] for formats that write; otherwise 0.
- `id_illegal` = `if_valid` and the opcode is illegal.

ID/EX register update, first matching rule wins:
- `reset` → all registered outputs 0.
- `flush` → `id_valid`, `id_reg_write` and `id_illegal` ← 0; other fields are don't-care, and the implementation sets them to 0.
- `stall` → all fields hold, except write-back snooping:
  - If `wb_wEn` and `wb_write_sel` ≠ 0 and `wb_write_sel` equals the held rs1 (or rs2) index, the corresponding `id_rsN_data` ← `wb_write_data`.
  - The block stores the rs1/rs2 indices internally (5 bits each) to support this.
- Otherwise → load all fields from the decode of `if_*`; `id_valid` ← `if_valid`.

## Timing
- Decode and read are combinational within the cycle; results are visible on `id_*` one cycle after the instruction is presented (latency 1).
- A value written back in cycle N is seen by an instruction decoded in cycle N through the bypass, with no bubble.
- When `flush` and `stall` are both asserted in the same cycle, flush wins.
- When `reset` is asserted mid-stream, all outputs are 0 on the following cycle regardless of `stall`/`flush`.
- A write-back to x0 never bypasses and never snoops.
- A held instruction may sit under `stall` for any number of cycles and must pick up every write-back to its sources during that time.

## Test plan
- Reset: assert `reset` for 2 cycles with `if_valid`=1 → every `id_*` output = 0. After release, `addi x5,x0,-1` (0xFFF00293) → next cycle:
  - `id_valid`=1, `id_rd`=5, `id_imm`=0xFFFFFFFF, `id_rs1_data`=0, `id_reg_write`=1.
- Bypass: `regFile` x2 = 0. In the same cycle, `wb_wEn`=1, `wb_write_sel`=2, `wb_write_data`=0xDEADBEEF, and present `add x3,x2,x2` (0x002101B3) →
  - `read_sel1` = `read_sel2` = 2.
  - Next cycle: `id_rs1_data` = `id_rs2_data` = 0xDEADBEEF, `id_rd`=3.
- Immediates:
  - LUI x1,0x12345 (0x123450B7) → `id_imm`=0x12345000, `read_sel1`=0.
  - beq x0,x0,-4 (0xFE000EE3) → `id_imm`=0xFFFFFFFC, `id_reg_write`=0.
- Stall snoop: latch add x3,x2,x2 with x2=5, hold `stall` 3 cycles, write back x2=9 during the second stall cycle →
  - `id_rs1_data` = `id_rs2_data` = 9 afterward.
  - All other fields unchanged.
- Flush priority: `stall`=1 and `flush`=1 together → next cycle `id_valid`=0 and `id_reg_write`=0.
- Illegal and x0 cases:
  - Instruction 0x00000073 → `id_illegal`=1, `id_reg_write`=0.
  - Write back x0=0x1234 while decoding `add x3,x0,x0` → `id_rs1_data`=0.
